// File: rtl/adc_trigger_sequencer.sv
// Conversion scheduler for the SPI ADC reader: emits periodic one-cycle trigger
// pulses and watches the reader's AXI-Stream handshake for accepted samples and overruns.
module adc_trigger_sequencer #(
  parameter int CNT_WIDTH  = 32,
  parameter int MIN_PERIOD = 16,
  parameter int OVR_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 adc_tvalid,
  input  logic                 adc_tready,
  output logic                 trigger,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [OVR_WIDTH-1:0] overrun_cnt,
  output logic [CNT_WIDTH-1:0] sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);

  state_t               state_q, state_n;
  logic [CNT_WIDTH-1:0] period_q, count_q;
  logic [CNT_WIDTH-1:0] phase_q, phase_n;
  logic [CNT_WIDTH-1:0] issued_q, issued_n;
  logic                 pending_q;
  logic                 trigger_n, done_n, start_run;
  logic                 accept, fire, last_fire;

  assign accept    = adc_tvalid & adc_tready;
  // trigger is registered from the phase==0 decode, so it doubles as the fire strobe
  assign fire      = (state_q == S_RUN) & trigger;
  assign last_fire = fire & (count_q != '0) & ((issued_q + 1'b1) == count_q);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_n   = state_q;
    phase_n   = phase_q;
    issued_n  = issued_q;
    done_n    = 1'b0;
    start_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_n   = S_RUN;
          phase_n   = '0;
          issued_n  = '0;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        phase_n = (phase_q >= period_q - 1'b1) ? '0 : phase_q + 1'b1;
        if (fire) issued_n = issued_q + 1'b1;
        if (stop || last_fire) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        // stop abandons an outstanding sample and skips the completion pulse
        if (stop) begin
          state_n = S_IDLE;
        end else if (!pending_q || accept) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    trigger_n = (state_n == S_RUN) && (phase_n == '0);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      count_q     <= '0;
      phase_q     <= '0;
      issued_q    <= '0;
      pending_q   <= 1'b0;
      trigger     <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      sample_cnt  <= '0;
    end else begin
      state_q  <= state_n;
      phase_q  <= phase_n;
      issued_q <= issued_n;
      trigger  <= trigger_n;
      done     <= done_n;
      if (start_run) begin
        period_q    <= (cfg_period < MIN_P) ? MIN_P : cfg_period;
        count_q     <= cfg_count;
        sample_cnt  <= '0;
        overrun     <= 1'b0;
        overrun_cnt <= '0;
        pending_q   <= 1'b0;
      end else begin
        if (accept) sample_cnt <= sample_cnt + 1'b1;
        if (fire) begin
          pending_q <= 1'b1;
          // a same-cycle accept retires the previous sample, so it is not an overrun
          if (pending_q && !accept) begin
            overrun <= 1'b1;
            if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
          end
        end else if (accept) begin
          pending_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_trigger_sequencer.sv
// Directed bench for adc_trigger_sequencer with a small reader model that
// raises tvalid a fixed latency after each trigger and holds it until accepted.
module tb_adc_trigger_sequencer;
  logic        aclk = 1'b0;
  logic        aresetn, start, stop, adc_tvalid, adc_tready;
  logic [31:0] cfg_period, cfg_count;
  logic        trigger, busy, done, overrun;
  logic [15:0] overrun_cnt;
  logic [31:0] sample_cnt;

  int tests = 0, fails = 0;
  int cyc = 0;
  int rd_lat = 12;
  int trig_q[$], done_q[$], tv_due[$];

  adc_trigger_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .adc_tvalid(adc_tvalid), .adc_tready(adc_tready),
    .trigger(trigger), .busy(busy), .done(done), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .sample_cnt(sample_cnt)
  );

  always #5 aclk = ~aclk;

  // one clock: cyc then names the cycle whose outputs are being observed
  task automatic cycle();
    bit acc;
    acc = adc_tvalid && adc_tready;
    @(posedge aclk); #1;
    cyc++;
    if (acc && tv_due.size() > 0) void'(tv_due.pop_front());
    if (trigger) begin trig_q.push_back(cyc); tv_due.push_back(cyc + rd_lat); end
    if (done) done_q.push_back(cyc);
    adc_tvalid = (tv_due.size() > 0) && (tv_due[0] <= cyc);
  endtask

  task automatic clr();
    trig_q.delete(); done_q.delete(); tv_due.delete();
    adc_tvalid = 1'b0;
  endtask

  task automatic do_start(input int p, input int c);
    clr();
    cfg_period = p; cfg_count = c;
    start = 1'b1; cyc = 0;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) cycle();
    tests++;
    if (trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got trg=%b busy=%b done=%b ovr=%b expected all 0", trigger, busy, done, overrun);
    end
    tests++;
    if (overrun_cnt !== 16'd0 || sample_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_cnts: got ovr_cnt=%0d smp=%0d expected 0 0", overrun_cnt, sample_cnt);
    end
    aresetn = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    do_start(20, 3);
    while (cyc < 60) cycle();
    tests++;
    if (trig_q.size() !== 3 || trig_q[0] !== 1 || trig_q[1] !== 21 || trig_q[2] !== 41) begin
      fails++; $display("FAIL basic_trig: got n=%0d %p expected 1 21 41", trig_q.size(), trig_q);
    end
    tests++;
    if (done_q.size() !== 1 || done_q[0] !== 54) begin
      fails++; $display("FAIL basic_done: got %p expected 54", done_q);
    end
    tests++;
    if (sample_cnt !== 32'd3 || overrun !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_end: got smp=%0d ovr=%b busy=%b expected 3 0 0", sample_cnt, overrun, busy);
    end
  endtask

  task automatic test_clamp();
    do_start(4, 2);
    while (cyc < 40) cycle();
    tests++;
    if (trig_q.size() !== 2 || trig_q[0] !== 1 || trig_q[1] !== 17) begin
      fails++; $display("FAIL clamp_trig: got %p expected 1 17", trig_q);
    end
    tests++;
    if (done_q.size() !== 1 || done_q[0] !== 30) begin
      fails++; $display("FAIL clamp_done: got %p expected 30", done_q);
    end
  endtask

  task automatic test_overrun();
    adc_tready = 1'b0;
    do_start(20, 4);
    while (cyc < 64) cycle();
    tests++;
    if (trig_q.size() !== 4 || trig_q[3] !== 61) begin
      fails++; $display("FAIL ovr_trig: got %p expected 1 21 41 61", trig_q);
    end
    tests++;
    if (overrun_cnt !== 16'd3 || overrun !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL ovr_cnt: got cnt=%0d ovr=%b busy=%b expected 3 1 1", overrun_cnt, overrun, busy);
    end
    adc_tready = 1'b1;
    cycle();
    adc_tready = 1'b0;
    clr();
    tests++;
    if (done !== 1'b1 || sample_cnt !== 32'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL ovr_drain: got done=%b smp=%0d busy=%b expected 1 1 0", done, sample_cnt, busy);
    end
    cycle();
    adc_tready = 1'b1;
  endtask

  task automatic test_continuous_stop();
    do_start(16, 0);
    while (cyc < 50) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    tests++;
    if (busy !== 1'b1 || trigger !== 1'b0) begin
      fails++; $display("FAIL cont_drain: got busy=%b trg=%b expected 1 0", busy, trigger);
    end
    while (cyc < 80) cycle();
    tests++;
    if (trig_q.size() !== 4 || trig_q[0] !== 1 || trig_q[1] !== 17 || trig_q[2] !== 33 || trig_q[3] !== 49) begin
      fails++; $display("FAIL cont_trig: got %p expected 1 17 33 49", trig_q);
    end
    tests++;
    if (done_q.size() !== 1 || done_q[0] !== 62 || sample_cnt !== 32'd4) begin
      fails++; $display("FAIL cont_done: got done=%p smp=%0d expected 62 4", done_q, sample_cnt);
    end
  endtask

  task automatic test_start_stop_idle();
    clr();
    cfg_period = 16; cfg_count = 1;
    start = 1'b1; stop = 1'b1; cyc = 0;
    cycle();
    start = 1'b0; stop = 1'b0;
    repeat (5) cycle();
    tests++;
    if (trig_q.size() !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL startstop_idle: got n_trig=%0d busy=%b expected 0 0", trig_q.size(), busy);
    end
  endtask

  task automatic test_start_in_run();
    do_start(20, 3);
    while (cyc < 5) cycle();
    cfg_period = 40; cfg_count = 1; start = 1'b1;
    cycle();
    start = 1'b0;
    while (cyc < 60) cycle();
    tests++;
    if (trig_q.size() !== 3 || trig_q[1] !== 21 || trig_q[2] !== 41) begin
      fails++; $display("FAIL start_in_run: got %p expected 1 21 41", trig_q);
    end
    tests++;
    if (done_q.size() !== 1 || done_q[0] !== 54 || sample_cnt !== 32'd3) begin
      fails++; $display("FAIL start_in_run_done: got %p smp=%0d expected 54 3", done_q, sample_cnt);
    end
  endtask

  task automatic test_back_to_back();
    rd_lat = 16;
    do_start(16, 3);
    while (cyc < 56) cycle();
    rd_lat = 12;
    tests++;
    if (overrun !== 1'b0 || overrun_cnt !== 16'd0) begin
      fails++; $display("FAIL coincident_ovr: got ovr=%b cnt=%0d expected 0 0", overrun, overrun_cnt);
    end
    tests++;
    if (done_q.size() !== 1 || done_q[0] !== 50 || sample_cnt !== 32'd3) begin
      fails++; $display("FAIL coincident_done: got %p smp=%0d expected 50 3", done_q, sample_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(20, 0);
    while (cyc < 30) cycle();
    tests++;
    if (busy !== 1'b1 || sample_cnt !== 32'd1) begin
      fails++; $display("FAIL midrst_pre: got busy=%b smp=%0d expected 1 1", busy, sample_cnt);
    end
    aresetn = 1'b0;
    cycle();
    aresetn = 1'b1;
    clr();
    tests++;
    if (trigger !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 16'd0 || sample_cnt !== 32'd0 || done !== 1'b0) begin
      fails++; $display("FAIL midrst_post: got trg=%b busy=%b ovr_cnt=%0d smp=%0d done=%b expected all 0",
                        trigger, busy, overrun_cnt, sample_cnt, done);
    end
    repeat (30) cycle();
    tests++;
    if (done_q.size() !== 0 || trig_q.size() !== 0) begin
      fails++; $display("FAIL midrst_quiet: got n_done=%0d n_trig=%0d expected 0 0", done_q.size(), trig_q.size());
    end
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; adc_tvalid = 1'b0; adc_tready = 1'b1;
    cfg_period = '0; cfg_count = '0; aresetn = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_overrun();
    test_continuous_stop();
    test_start_stop_idle();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
